// File: rtl/axi4lite_slave_regs.sv
// -----------------------------------------------------------------------------
// axi4lite_slave_regs
//   AXI4-Lite responder backed by a small bank of read/write registers.
//   Single-beat transfers only; at most one outstanding transaction on the
//   write channel and one on the read channel. The two channels run
//   independently of each other.
//
//   Optional build macro: AXIL_SLVERR_EN
//     defined     -> accesses to unmapped indices answer SLVERR (2'b10)
//     not defined -> unmapped accesses answer OKAY (2'b00)
//   In both builds unmapped writes are dropped and unmapped reads return 0.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   s_aw*                      write address channel (addr, valid, ready)
//   s_w*                       write data channel    (data, valid, ready)
//   s_b*                       write response channel (resp, valid, ready)
//   s_ar*                      read address channel  (addr, valid, ready)
//   s_r*                       read data channel     (data, resp, valid, ready)
//   regs_out                   flat register contents, reg i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module axi4lite_slave_regs #(
    parameter int                ADDR_W    = 2,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REGS  = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          s_awaddr,
    input  logic                       s_awvalid,
    output logic                       s_awready,
    input  logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_wvalid,
    output logic                       s_wready,
    output logic [1:0]                 s_bresp,
    output logic                       s_bvalid,
    input  logic                       s_bready,
    input  logic [ADDR_W-1:0]          s_araddr,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [DATA_W-1:0]          s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic [NUM_REGS*DATA_W-1:0] regs_out
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GOT_AW = 2'd1,
        W_GOT_W  = 2'd2,
        W_RESP   = 2'd3
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_e;

    // True when the index addresses an implemented register.
    function automatic logic is_mapped(input logic [ADDR_W-1:0] idx);
        return (32'(idx) < 32'(NUM_REGS));
    endfunction

    // Response code for an access to the given index.
    function automatic logic [1:0] resp_for(input logic [ADDR_W-1:0] idx);
`ifdef AXIL_SLVERR_EN
        return is_mapped(idx) ? RESP_OKAY : RESP_SLVERR;
`else
        return RESP_OKAY;
`endif
    endfunction

    wstate_e             wstate_q;
    rstate_e             rstate_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                awready_q;
    logic                wready_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic                arready_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                aw_hs_s;
    logic                w_hs_s;
    logic                ar_hs_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_idx_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [DATA_W-1:0]   rd_data_s;

    assign aw_hs_s = s_awvalid & awready_q;
    assign w_hs_s  = s_wvalid  & wready_q;
    assign ar_hs_s = s_arvalid & arready_q;

    // Commit strobe: fires on the edge that completes the AW/W pair, taking
    // whichever half was captured earlier from its holding register.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = s_awaddr;
        wr_data_s = s_wdata;
        case (wstate_q)
            W_IDLE:   wr_en_s = aw_hs_s & w_hs_s;
            W_GOT_AW: begin
                wr_idx_s = awaddr_q;
                wr_en_s  = w_hs_s;
            end
            W_GOT_W:  begin
                wr_data_s = wdata_q;
                wr_en_s   = aw_hs_s;
            end
            default:  wr_en_s = 1'b0;
        endcase
    end

    // Read mux; unmapped indices read as zero.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (s_araddr == ADDR_W'(i)) begin
                rd_data_s = regs_q[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Register bank; unmapped writes match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (wr_idx_s == ADDR_W'(i))) begin
                    regs_q[i] <= wr_data_s;
                end
            end
        end
    end

    // Write channel FSM: captures AW and W independently, then holds B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q  <= W_IDLE;
            awaddr_q  <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs_s && w_hs_s) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= resp_for(s_awaddr);
                        wstate_q  <= W_RESP;
                    end else if (aw_hs_s) begin
                        awaddr_q  <= s_awaddr;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_GOT_AW;
                    end else if (w_hs_s) begin
                        wdata_q   <= s_wdata;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                        wstate_q  <= W_GOT_W;
                    end else begin
                        // Also raises the readies on the first edge after reset.
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_GOT_AW: begin
                    if (w_hs_s) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= resp_for(awaddr_q);
                        wstate_q <= W_RESP;
                    end
                end
                W_GOT_W: begin
                    if (aw_hs_s) begin
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= resp_for(s_awaddr);
                        wstate_q  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    wstate_q  <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: samples the bank on the AR handshake edge, so a write
    // committing on that same edge is not yet visible to this read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rdata_q   <= rd_data_s;
                        rresp_q   <= resp_for(s_araddr);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b0;
                    rstate_q  <= R_IDLE;
                end
            endcase
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_slave_regs
//   Directed bench for axi4lite_slave_regs built with NUM_REGS = 3 so that
//   index 3 is unmapped. Inputs change 1 ns after a rising edge and outputs
//   are sampled at that same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_axi4lite_slave_regs;

    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 3;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    logic                       clk;
    logic                       rst_n;
    logic [ADDR_W-1:0]          s_awaddr;
    logic                       s_awvalid;
    logic                       s_awready;
    logic [DATA_W-1:0]          s_wdata;
    logic                       s_wvalid;
    logic                       s_wready;
    logic [1:0]                 s_bresp;
    logic                       s_bvalid;
    logic                       s_bready;
    logic [ADDR_W-1:0]          s_araddr;
    logic                       s_arvalid;
    logic                       s_arready;
    logic [DATA_W-1:0]          s_rdata;
    logic [1:0]                 s_rresp;
    logic                       s_rvalid;
    logic                       s_rready;
    logic [NUM_REGS*DATA_W-1:0] regs_out;

    int checks;
    int errors;

    axi4lite_slave_regs #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RESET_VAL(8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_awaddr (s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata  (s_wdata),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_araddr (s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .regs_out (regs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        s_awaddr  = 2'd0;
        s_awvalid = 1'b0;
        s_wdata   = 8'h00;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = 2'd0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_wready",  32'(s_wready),  32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        chk("rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("rst_bresp",   32'(s_bresp),   32'd0);
        chk("rst_rresp",   32'(s_rresp),   32'd0);
        chk("rst_rdata",   32'(s_rdata),   32'd0);
        chk("rst_regs",    32'(regs_out),  32'd0);
        rst_n = 1'b1;
        chk("rel_awready_still_low", 32'(s_awready), 32'd0);
        tick();
        chk("rel_awready", 32'(s_awready), 32'd1);
        chk("rel_wready",  32'(s_wready),  32'd1);
        chk("rel_arready", 32'(s_arready), 32'd1);

        // T1: AW+W same cycle to reg 1
        s_awaddr = 2'd1; s_awvalid = 1'b1;
        s_wdata = 8'hAA; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t1_bvalid",  32'(s_bvalid),        32'd1);
        chk("t1_bresp",   32'(s_bresp),         32'd0);
        chk("t1_awready", 32'(s_awready),       32'd0);
        chk("t1_wready",  32'(s_wready),        32'd0);
        chk("t1_reg1",    32'(regs_out[15:8]),  32'hAA);
        tick();
        chk("t1_bdone",   32'(s_bvalid),  32'd0);
        chk("t1_awrdy2",  32'(s_awready), 32'd1);
        chk("t1_wrdy2",   32'(s_wready),  32'd1);

        // T2: W leads AW by 3 cycles, reg 2
        s_wdata = 8'h55; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        chk("t2_wready_low", 32'(s_wready),  32'd0);
        chk("t2_awready",    32'(s_awready), 32'd1);
        chk("t2_no_b",       32'(s_bvalid),  32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t2_wait_wready", 32'(s_wready), 32'd0);
            chk("t2_wait_bvalid", 32'(s_bvalid), 32'd0);
        end
        s_awaddr = 2'd2; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        chk("t2_bvalid", 32'(s_bvalid),        32'd1);
        chk("t2_reg2",   32'(regs_out[23:16]), 32'h55);
        chk("t2_reg1",   32'(regs_out[15:8]),  32'hAA);
        tick();
        chk("t2_bdone", 32'(s_bvalid), 32'd0);
        tick();
        chk("t2_single_b", 32'(s_bvalid), 32'd0);
        chk("t2_wready_back", 32'(s_wready), 32'd1);

        // T3: read reg 1 with rready held low 4 cycles
        s_araddr = 2'd1; s_arvalid = 1'b1; s_rready = 1'b0;
        tick();
        s_arvalid = 1'b0;
        chk("t3_rvalid",  32'(s_rvalid),  32'd1);
        chk("t3_rdata",   32'(s_rdata),   32'hAA);
        chk("t3_rresp",   32'(s_rresp),   32'd0);
        chk("t3_arready", 32'(s_arready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_hold_rvalid",  32'(s_rvalid),  32'd1);
            chk("t3_hold_rdata",   32'(s_rdata),   32'hAA);
            chk("t3_hold_arready", 32'(s_arready), 32'd0);
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("t3_rdone",    32'(s_rvalid),  32'd1 - 32'd1);
        chk("t3_arready2", 32'(s_arready), 32'd1);

        // T4: B held low 5 cycles blocks a second write (reg 0)
        s_awaddr = 2'd0; s_awvalid = 1'b1;
        s_wdata = 8'h3C; s_wvalid = 1'b1; s_bready = 1'b0;
        tick();
        chk("t4_bvalid", 32'(s_bvalid),       32'd1);
        chk("t4_reg0",   32'(regs_out[7:0]),  32'h3C);
        s_wdata = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_bvalid",  32'(s_bvalid),      32'd1);
            chk("t4_hold_awready", 32'(s_awready),     32'd0);
            chk("t4_hold_wready",  32'(s_wready),      32'd0);
            chk("t4_hold_reg0",    32'(regs_out[7:0]), 32'h3C);
        end
        s_bready = 1'b1;
        tick();
        chk("t4_bdone",   32'(s_bvalid),  32'd0);
        chk("t4_awready", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t4_second_b",    32'(s_bvalid),      32'd1);
        chk("t4_second_reg0", 32'(regs_out[7:0]), 32'hC3);
        tick();
        chk("t4_second_bdone", 32'(s_bvalid), 32'd0);

        // T5: reset asserted after AW only
        s_awaddr = 2'd1; s_awvalid = 1'b1; s_bready = 1'b0;
        tick();
        s_awvalid = 1'b0;
        chk("t5_got_aw", 32'(s_awready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_bvalid",  32'(s_bvalid),  32'd0);
        chk("t5_rst_rvalid",  32'(s_rvalid),  32'd0);
        chk("t5_rst_awready", 32'(s_awready), 32'd0);
        chk("t5_rst_regs",    32'(regs_out),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("t5_awready", 32'(s_awready), 32'd1);
        chk("t5_wready",  32'(s_wready),  32'd1);
        s_awaddr = 2'd2; s_awvalid = 1'b1;
        s_wdata = 8'h77; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t5_bvalid", 32'(s_bvalid), 32'd1);
        chk("t5_regs",   32'(regs_out), 32'h770000);
        tick();
        chk("t5_bdone", 32'(s_bvalid), 32'd0);

        // T6: write and read of reg 2 on the same edge returns the old value
        s_awaddr = 2'd2; s_awvalid = 1'b1;
        s_wdata = 8'h99; s_wvalid = 1'b1; s_bready = 1'b1;
        s_araddr = 2'd2; s_arvalid = 1'b1; s_rready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chk("t6_rvalid", 32'(s_rvalid),        32'd1);
        chk("t6_rdata",  32'(s_rdata),         32'h77);
        chk("t6_bvalid", 32'(s_bvalid),        32'd1);
        chk("t6_reg2",   32'(regs_out[23:16]), 32'h99);
        tick();
        chk("t6_rdone", 32'(s_rvalid), 32'd0);
        chk("t6_bdone", 32'(s_bvalid), 32'd0);
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("t6_reread", 32'(s_rdata), 32'h99);
        tick();

        // T7: unmapped index 3
        s_awaddr = 2'd3; s_awvalid = 1'b1;
        s_wdata = 8'hEE; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("t7_bvalid", 32'(s_bvalid), 32'd1);
        chk("t7_bresp",  32'(s_bresp),  32'(UNMAP_RESP));
        chk("t7_regs",   32'(regs_out), 32'h990000);
        tick();
        s_araddr = 2'd3; s_arvalid = 1'b1; s_rready = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("t7_rvalid", 32'(s_rvalid), 32'd1);
        chk("t7_rdata",  32'(s_rdata),  32'd0);
        chk("t7_rresp",  32'(s_rresp),  32'(UNMAP_RESP));
        tick();
        chk("t7_rdone", 32'(s_rvalid), 32'd0);
        s_araddr = 2'd2; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("t7_mapped_rresp", 32'(s_rresp), 32'd0);
        chk("t7_mapped_rdata", 32'(s_rdata), 32'h99);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
